// File: rtl/memory_stage.sv
// Memory pipeline stage: latches execute results and drives the data-memory handshake.
// Also stalls the front end while a request is outstanding and aborts requests that wait too long.
`ifndef IR_SRC_DATA
`define IR_SRC_DATA 2'd0
`endif
`ifndef IR_SRC_NOP
`define IR_SRC_NOP 2'd1
`endif
`ifndef IR_SRC_EXCEPT
`define IR_SRC_EXCEPT 2'd2
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif
`ifndef INST_BNE_EXCEPT
`define INST_BNE_EXCEPT 32'h0000_1063
`endif

module memory_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  ir_src_mem,
    input  logic        op_ld_or_ldr,
    input  logic        op_st,
    input  logic        rf_w_mux_jump,
    input  logic [31:0] pc,
    input  logic [31:0] ir,
    input  logic [31:0] y,
    input  logic [31:0] d,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] pc_next,
    output logic [31:0] ir_next,
    output logic [31:0] y_next,
    output logic [31:0] mdata_next,
    output logic        op_ld_or_ldr_next,
    output logic        rf_w_mux_jump_next
);

    typedef enum logic [1:0] {StIdle, StWait, StAbort} state_e;

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [8:0]  cnt_inc;
    logic        timeout_hit;

    logic [31:0] pc_m, ir_m, y_m, d_m;
    logic        ld_m, st_m, jmp_m;
    logic        mem_op, aligned, abort;

    assign mem_op  = ld_m | st_m;
    assign aligned = (y_m[1:0] == 2'b00);
    assign abort   = (state_q == StAbort);

    assign dmem_req   = mem_op & aligned & ~abort;
    assign dmem_we    = st_m;
    assign dmem_addr  = {y_m[31:2], 2'b00};
    assign dmem_wdata = d_m;
    assign stall      = dmem_req & ~dmem_ack;

    // Stage registers freeze during a stall so the request stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_m  <= '0;
            ir_m  <= `INST_NOP;
            y_m   <= '0;
            d_m   <= '0;
            ld_m  <= 1'b0;
            st_m  <= 1'b0;
            jmp_m <= 1'b0;
        end else if (!stall) begin
            pc_m  <= pc;
            ir_m  <= ir;
            y_m   <= y;
            d_m   <= d;
            ld_m  <= op_ld_or_ldr;
            st_m  <= op_st;
            jmp_m <= rf_w_mux_jump;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign cnt_inc     = {1'b0, wait_cnt_q} + 9'd1;
    assign timeout_hit = ({23'd0, cnt_inc} >= TIMEOUT);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            StIdle: begin
                wait_cnt_d = '0;
                if (dmem_req && !dmem_ack) state_d = StWait;
            end
            StWait: begin
                if (dmem_ack) begin
                    state_d    = StIdle;
                    wait_cnt_d = '0;
                end else begin
                    // Saturate rather than wrap.
                    if (wait_cnt_q != 8'hff) wait_cnt_d = cnt_inc[7:0];
                    if (timeout_hit) state_d = StAbort;
                end
            end
            StAbort: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ir_next = `INST_NOP;
        if (stall) begin
            ir_next = `INST_NOP;
        end else if (abort || (mem_op && !aligned)) begin
            ir_next = `INST_BNE_EXCEPT;
        end else begin
            case (ir_src_mem)
                `IR_SRC_DATA:   ir_next = ir_m;
                `IR_SRC_NOP:    ir_next = `INST_NOP;
                `IR_SRC_EXCEPT: ir_next = `INST_BNE_EXCEPT;
                default:        ir_next = 'x;
            endcase
        end
    end

    // A simultaneous ld/st is a store, so it never reports load data.
    assign op_ld_or_ldr_next  = ld_m & ~st_m & aligned & ~stall & ~abort;
    assign mdata_next         = dmem_rdata;
    assign pc_next            = pc_m;
    assign y_next             = y_m;
    assign rf_w_mux_jump_next = jmp_m;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: single-cycle vector table plus multi-cycle wait,
// timeout and reset sequences.
`ifndef IR_SRC_DATA
`define IR_SRC_DATA 2'd0
`endif
`ifndef IR_SRC_NOP
`define IR_SRC_NOP 2'd1
`endif
`ifndef IR_SRC_EXCEPT
`define IR_SRC_EXCEPT 2'd2
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif
`ifndef INST_BNE_EXCEPT
`define INST_BNE_EXCEPT 32'h0000_1063
`endif

module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ir_src_mem;
    logic        op_ld_or_ldr, op_st, rf_w_mux_jump;
    logic [31:0] pc, ir, y, d;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        stall;
    logic [31:0] pc_next, ir_next, y_next, mdata_next;
    logic        op_ld_or_ldr_next, rf_w_mux_jump_next;

    int n_checks = 0;
    int n_fail   = 0;

    memory_stage #(.TIMEOUT(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .ir_src_mem         (ir_src_mem),
        .op_ld_or_ldr       (op_ld_or_ldr),
        .op_st              (op_st),
        .rf_w_mux_jump      (rf_w_mux_jump),
        .pc                 (pc),
        .ir                 (ir),
        .y                  (y),
        .d                  (d),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_ack           (dmem_ack),
        .dmem_rdata         (dmem_rdata),
        .stall              (stall),
        .pc_next            (pc_next),
        .ir_next            (ir_next),
        .y_next             (y_next),
        .mdata_next         (mdata_next),
        .op_ld_or_ldr_next  (op_ld_or_ldr_next),
        .rf_w_mux_jump_next (rf_w_mux_jump_next)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  src;
        logic        ld, st, jmp;
        logic [31:0] pc, ir, y, d;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req, e_we, e_stall, e_ld;
        logic [31:0] e_ir;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        ir_src_mem    = `IR_SRC_NOP;
        op_ld_or_ldr  = 1'b0;
        op_st         = 1'b0;
        rf_w_mux_jump = 1'b0;
        pc            = '0;
        ir            = `INST_NOP;
        y             = '0;
        d             = '0;
    endtask

    task automatic issue_load(input logic [31:0] addr, input logic [31:0] inst);
        bubble();
        ir_src_mem   = `IR_SRC_DATA;
        op_ld_or_ldr = 1'b1;
        y            = addr;
        ir           = inst;
        dmem_ack     = 1'b0;
    endtask

    initial begin
        vecs[0] = '{`IR_SRC_DATA, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0000_2083, 32'h100, 32'h0,
                    1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_2083};
        vecs[1] = '{`IR_SRC_DATA, 1'b0, 1'b1, 1'b0, 32'h44, 32'h0000_a023, 32'h208, 32'hCAFEF00D,
                    1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_a023};
        vecs[2] = '{`IR_SRC_DATA, 1'b1, 1'b0, 1'b0, 32'h48, 32'h0000_2103, 32'h102, 32'h0,
                    1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, `INST_BNE_EXCEPT};
        vecs[3] = '{`IR_SRC_DATA, 1'b0, 1'b1, 1'b0, 32'h4c, 32'h0000_b023, 32'h203, 32'h77,
                    1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, `INST_BNE_EXCEPT};
        vecs[4] = '{`IR_SRC_NOP, 1'b0, 1'b0, 1'b0, 32'h50, 32'h0020_81b3, 32'h1234, 32'h0,
                    1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, `INST_NOP};
        vecs[5] = '{`IR_SRC_EXCEPT, 1'b0, 1'b0, 1'b0, 32'h54, 32'h0020_81b3, 32'h5, 32'h0,
                    1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, `INST_BNE_EXCEPT};
        vecs[6] = '{`IR_SRC_DATA, 1'b0, 1'b0, 1'b1, 32'h58, 32'h0080_00ef, 32'h5c, 32'h0,
                    1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0080_00ef};
        vecs[7] = '{`IR_SRC_DATA, 1'b1, 1'b1, 1'b0, 32'h60, 32'h0000_c023, 32'h300, 32'hA5A5A5A5,
                    1'b1, 32'h1111, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_c023};
        vecs[8] = '{`IR_SRC_DATA, 1'b1, 1'b0, 1'b0, 32'h64, 32'h0000_2283, 32'hFFFF_FFFC, 32'h0,
                    1'b1, 32'h0BADF00D, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_2283};

        // Reset
        bubble();
        ir_src_mem = `IR_SRC_DATA;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        rst        = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        chk("reset req", 32'(dmem_req), 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset ir_next", ir_next, `INST_NOP);
        chk("reset pc_next", pc_next, 32'd0);
        chk("reset y_next", y_next, 32'd0);
        chk("reset ld_next", 32'(op_ld_or_ldr_next), 32'd0);
        chk("reset jmp_next", 32'(rf_w_mux_jump_next), 32'd0);

        // Vector table: one load cycle, then one check cycle with a bubble behind it
        for (int i = 0; i < 9; i++) begin
            cycle();
            ir_src_mem    = vecs[i].src;
            op_ld_or_ldr  = vecs[i].ld;
            op_st         = vecs[i].st;
            rf_w_mux_jump = vecs[i].jmp;
            pc            = vecs[i].pc;
            ir            = vecs[i].ir;
            y             = vecs[i].y;
            d             = vecs[i].d;
            dmem_ack      = 1'b0;
            cycle();
            bubble();
            ir_src_mem = vecs[i].src;
            dmem_ack   = vecs[i].ack;
            dmem_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("vec%0d req", i), 32'(dmem_req), 32'(vecs[i].e_req));
            chk($sformatf("vec%0d stall", i), 32'(stall), 32'(vecs[i].e_stall));
            chk($sformatf("vec%0d ir_next", i), ir_next, vecs[i].e_ir);
            chk($sformatf("vec%0d ld_next", i), 32'(op_ld_or_ldr_next), 32'(vecs[i].e_ld));
            chk($sformatf("vec%0d pc_next", i), pc_next, vecs[i].pc);
            chk($sformatf("vec%0d y_next", i), y_next, vecs[i].y);
            chk($sformatf("vec%0d jmp_next", i), 32'(rf_w_mux_jump_next), 32'(vecs[i].jmp));
            if (vecs[i].e_req) begin
                chk($sformatf("vec%0d we", i), 32'(dmem_we), 32'(vecs[i].e_we));
                chk($sformatf("vec%0d addr", i), dmem_addr, vecs[i].y & 32'hFFFF_FFFC);
                if (vecs[i].e_we) chk($sformatf("vec%0d wdata", i), dmem_wdata, vecs[i].d);
            end
            if (vecs[i].e_ld) chk($sformatf("vec%0d mdata", i), mdata_next, vecs[i].rdata);
        end
        cycle();
        dmem_ack = 1'b0;

        // Store with three wait cycles; inputs change under the stall
        bubble();
        ir_src_mem = `IR_SRC_DATA;
        op_st      = 1'b1;
        pc         = 32'h80;
        ir         = 32'h0041_2023;
        y          = 32'h204;
        d          = 32'h1234_5678;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (k < 3) begin
                ir_src_mem   = `IR_SRC_DATA;
                op_ld_or_ldr = 1'b1;
                op_st        = 1'b0;
                y            = 32'h999 + 32'(k);
                d            = 32'hFFFF_0000;
                ir           = 32'h11;
            end else begin
                bubble();
                ir_src_mem = `IR_SRC_DATA;
            end
            dmem_ack = (k == 3);
            #1;
            chk($sformatf("st3 req c%0d", k), 32'(dmem_req), 32'd1);
            chk($sformatf("st3 we c%0d", k), 32'(dmem_we), 32'd1);
            chk($sformatf("st3 addr c%0d", k), dmem_addr, 32'h204);
            chk($sformatf("st3 wdata c%0d", k), dmem_wdata, 32'h1234_5678);
            chk($sformatf("st3 stall c%0d", k), 32'(stall), (k < 3) ? 32'd1 : 32'd0);
            chk($sformatf("st3 ir_next c%0d", k), ir_next,
                (k < 3) ? `INST_NOP : 32'h0041_2023);
        end
        cycle();
        dmem_ack = 1'b0;
        bubble();
        #1;
        chk("st3 after req", 32'(dmem_req), 32'd0);
        chk("st3 after y_next", y_next, 32'd0);
        chk("st3 after ir_next", ir_next, `INST_NOP);

        // Load timeout: five stalled cycles (IDLE + 4 WAIT), then ABORT
        issue_load(32'h400, 32'h0040_2103);
        for (int k = 0; k < 5; k++) begin
            cycle();
            bubble();
            ir_src_mem = `IR_SRC_DATA;
            #1;
            chk($sformatf("tmo stall c%0d", k), 32'(stall), 32'd1);
            chk($sformatf("tmo req c%0d", k), 32'(dmem_req), 32'd1);
        end
        cycle();
        #1;
        chk("tmo abort req", 32'(dmem_req), 32'd0);
        chk("tmo abort stall", 32'(stall), 32'd0);
        chk("tmo abort ir_next", ir_next, `INST_BNE_EXCEPT);
        chk("tmo abort ld_next", 32'(op_ld_or_ldr_next), 32'd0);
        chk("tmo abort y_next", y_next, 32'h400);
        cycle();
        #1;
        chk("tmo post req", 32'(dmem_req), 32'd0);
        chk("tmo post ir_next", ir_next, `INST_NOP);
        issue_load(32'h104, 32'h0040_2183);
        cycle();
        bubble();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h0000_55AA;
        #1;
        chk("tmo idle req", 32'(dmem_req), 32'd1);
        chk("tmo idle stall", 32'(stall), 32'd0);
        chk("tmo idle mdata", mdata_next, 32'h0000_55AA);
        chk("tmo idle ld_next", 32'(op_ld_or_ldr_next), 32'd1);
        cycle();
        dmem_ack = 1'b0;

        // Reset during the second WAIT cycle; a late ack must be ignored
        issue_load(32'h500, 32'h0050_2203);
        cycle();
        bubble();
        #1;
        chk("rstw idle stall", 32'(stall), 32'd1);
        cycle();
        #1;
        chk("rstw wait1 stall", 32'(stall), 32'd1);
        cycle();
        rst = 1'b1;
        #1;
        chk("rstw wait2 stall", 32'(stall), 32'd1);
        cycle();
        rst        = 1'b0;
        ir_src_mem = `IR_SRC_DATA;
        #1;
        chk("rstw req", 32'(dmem_req), 32'd0);
        chk("rstw stall", 32'(stall), 32'd0);
        chk("rstw ir_next", ir_next, `INST_NOP);
        chk("rstw ld_next", 32'(op_ld_or_ldr_next), 32'd0);
        chk("rstw pc_next", pc_next, 32'd0);
        cycle();
        dmem_ack = 1'b1;
        #1;
        chk("rstw late ack req", 32'(dmem_req), 32'd0);
        chk("rstw late ack stall", 32'(stall), 32'd0);
        cycle();
        issue_load(32'h600, 32'h0060_2283);
        cycle();
        bubble();
        #1;
        chk("rstw new req", 32'(dmem_req), 32'd1);
        chk("rstw new stall", 32'(stall), 32'd1);
        cycle();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h0F0F_0F0F;
        #1;
        chk("rstw new done stall", 32'(stall), 32'd0);
        chk("rstw new mdata", mdata_next, 32'h0F0F_0F0F);
        chk("rstw new ld_next", 32'(op_ld_or_ldr_next), 32'd1);
        cycle();
        dmem_ack = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
